ram_512x16: RTL and testbench



---
 rtl/hack_mem_pkg.sv | 14 +
 rtl/ram_64x16.sv | 35 +++
 rtl/ram_512x16.sv | 49 ++++
 tb/tb_ram_512x16.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/hack_mem_pkg.sv
// rtl/hack_mem_pkg.sv - shared constants and word type for the Hack memory hierarchy
package hack_mem_pkg;

  // Width of every stored word at every level of the hierarchy.
  localparam int DATA_WIDTH = 16;

  // Address widths per hierarchy level.
  localparam int RAM8_AW   = 3;
  localparam int RAM64_AW  = 6;
  localparam int RAM512_AW = 9;

  typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/ram_64x16.sv
// rtl/ram_64x16.sv - 64-word bank: clocked write, combinational read, sync clear
module ram_64x16 #(
  parameter int DATA_WIDTH = hack_mem_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = hack_mem_pkg::RAM64_AW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] out
);
  import hack_mem_pkg::*;

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Reset wipes the whole bank and outranks any write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (load) begin
      mem[address] <= in;
    end
  end

  // Read is a plain mux of the storage; no bypass from in before the edge.
  always_comb begin
    out = mem[address];
  end

endmodule

// File: rtl/ram_512x16.sv
// rtl/ram_512x16.sv - 512-word memory built from eight 64-word banks
module ram_512x16 #(
  parameter int DATA_WIDTH = hack_mem_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = hack_mem_pkg::RAM512_AW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] out
);
  import hack_mem_pkg::*;

  // Upper address bits pick the bank, lower bits pick the word inside it.
  localparam int SEL_W   = ADDR_WIDTH - RAM64_AW;
  localparam int N_BANKS = 1 << SEL_W;

  logic [SEL_W-1:0]      bank_sel;
  logic [RAM64_AW-1:0]   bank_addr;
  logic [N_BANKS-1:0]    bank_load;
  logic [DATA_WIDTH-1:0] bank_out [N_BANKS];

  assign bank_sel  = address[ADDR_WIDTH-1:RAM64_AW];
  assign bank_addr = address[RAM64_AW-1:0];

  for (genvar i = 0; i < N_BANKS; i++) begin : g_bank
    // Only the selected bank sees the write enable.
    assign bank_load[i] = load && (bank_sel == SEL_W'(i));

    ram_64x16 #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (RAM64_AW)
    ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .in      (in),
      .load    (bank_load[i]),
      .address (bank_addr),
      .out     (bank_out[i])
    );
  end

  // Output mux over the bank read ports.
  always_comb begin
    out = bank_out[bank_sel];
  end

endmodule

// File: tb/tb_ram_512x16.sv
// tb/tb_ram_512x16.sv - scoreboard bench for ram_512x16
module tb_ram_512x16;
  import hack_mem_pkg::*;

  logic        clk;
  logic        reset;
  word_t       in;
  logic        load;
  logic [8:0]  address;
  word_t       out;

  logic        rd_valid;
  word_t       exp_q[$];
  string       name_q[$];
  int          checks;
  int          failures;

  ram_512x16 dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in),
    .load    (load),
    .address (address),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: each rd_valid strobe pops one expected word and compares with out.
  always @(posedge rd_valid) begin
    word_t exp_v;
    string nm;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_underflow actual=%h required=<queued entry>", out);
    end else begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      checks++;
      if (out !== exp_v) begin
        failures++;
        $display("FAIL %s actual=%h required=%h", nm, out, exp_v);
      end
    end
  end

  // Sample out right now at the current address.
  task automatic sample(input string nm, input word_t e);
    #1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    rd_valid = 1'b1;
    #1;
    rd_valid = 1'b0;
  endtask

  // Move address mid-cycle (no clock edge) and sample.
  task automatic read_now(input logic [8:0] a, input word_t e, input string nm);
    address = a;
    load    = 1'b0;
    sample(nm, e);
  endtask

  // Read from the middle of the low phase.
  task automatic read_at(input logic [8:0] a, input word_t e, input string nm);
    @(negedge clk);
    read_now(a, e, nm);
  endtask

  task automatic write_word(input logic [8:0] a, input word_t d);
    @(negedge clk);
    address = a;
    in      = d;
    load    = 1'b1;
    @(posedge clk);
    #1;
    load    = 1'b0;
  endtask

  task automatic idle_clocks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rd_valid = 1'b0;
    reset    = 1'b1;
    load     = 1'b0;
    in       = '0;
    address  = '0;
    idle_clocks(2);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    read_at(9'd0,   16'h0000, "reset_addr0");
    read_at(9'd42,  16'h0000, "reset_addr42");
    read_at(9'd511, 16'h0000, "reset_addr511");

    // Basic write/read, then a non-load edge with in=0
    write_word(9'd42, 16'hDEAD);
    sample("basic_after_edge", 16'hDEAD);
    @(negedge clk);
    in = 16'h0000;
    load = 1'b0;
    @(posedge clk);
    read_at(9'd42, 16'hDEAD, "basic_hold");

    // Isolation across bank boundaries
    write_word(9'd0,   16'h1111);
    write_word(9'd63,  16'h2222);
    write_word(9'd64,  16'h3333);
    write_word(9'd511, 16'hFFFF);
    read_at(9'd0,   16'h1111, "iso_addr0");
    read_at(9'd63,  16'h2222, "iso_addr63");
    read_at(9'd64,  16'h3333, "iso_addr64");
    read_at(9'd511, 16'hFFFF, "iso_addr511");
    read_at(9'd1,   16'h0000, "iso_addr1");
    read_at(9'd65,  16'h0000, "iso_addr65");
    read_at(9'd42,  16'hDEAD, "iso_addr42");

    // No-load hold
    write_word(9'd300, 16'hBEEF);
    @(negedge clk);
    address = 9'd300;
    in      = 16'h1234;
    load    = 1'b0;
    idle_clocks(3);
    read_at(9'd300, 16'hBEEF, "hold_addr300");

    // Combinational read: address moves between edges
    write_word(9'd5,   16'hAAAA);
    write_word(9'd500, 16'h5555);
    @(negedge clk);
    read_now(9'd5,   16'hAAAA, "comb_addr5");
    read_now(9'd500, 16'h5555, "comb_addr500");
    read_now(9'd5,   16'hAAAA, "comb_addr5_again");

    // Reset priority over a simultaneous write
    @(negedge clk);
    reset   = 1'b1;
    load    = 1'b1;
    address = 9'd42;
    in      = 16'h7777;
    @(posedge clk);
    #1;
    reset = 1'b0;
    load  = 1'b0;
    read_at(9'd42,  16'h0000, "rst_prio_addr42");
    read_at(9'd511, 16'h0000, "rst_clear_addr511");
    read_at(9'd300, 16'h0000, "rst_clear_addr300");
    read_at(9'd500, 16'h0000, "rst_clear_addr500");

    // Overwrite on consecutive edges, with read-during-write checks
    @(negedge clk);
    address = 9'd257;
    in      = 16'h0001;
    load    = 1'b1;
    sample("rdw_before_first", 16'h0000);
    @(posedge clk);
    sample("ovw_after_first", 16'h0001);
    in = 16'h8000;
    sample("rdw_before_second", 16'h0001);
    @(posedge clk);
    sample("ovw_after_second", 16'h8000);
    load = 1'b0;
    read_at(9'd257, 16'h8000, "ovw_settled");
    read_at(9'd256, 16'h0000, "ovw_neighbor256");

    #20;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
